// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiplier with MUL/MLA/UMULL/SMULL modes.
// A started operation takes WIDTH cycles in CALC, one multiplier bit per cycle,
// and then spends one cycle in DONE with a single-cycle done pulse. Result,
// ResultExtra and Flags are registered, and they hold their values until the
// next operation finishes.
module mul_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       MulOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] Acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultExtra,
  output logic [3:0]       Flags
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MLA   = 2'b01,
    OP_UMULL = 2'b10,
    OP_SMULL = 2'b11
  } mulop_t;

  state_t            state_q, state_d;
  mulop_t            op_q, op_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [W2-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic              neg_q, neg_d;
  logic [W2-1:0]     prod_q, prod_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH-1:0]  extra_q, extra_d;
  logic [3:0]        flags_q, flags_d;

  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [W2-1:0]     prod_step;
  logic [W2-1:0]     final_p;
  logic              long_op;
  logic              last_iter;

  // The operand magnitudes for SMULL are taken here. The most-negative value maps onto itself.
  // As an unsigned number that is 2^(W-1), which is the correct magnitude.
  always_comb begin
    a_mag = A;
    b_mag = B;
    if (mulop_t'(MulOp) == OP_SMULL) begin
      if (A[WIDTH-1]) a_mag = -A;
      if (B[WIDTH-1]) b_mag = -B;
    end
  end

  // This block performs one shift-add step and applies the per-op finishing to form the final value.
  // The finishing is applied to the product after the step, so the last iteration and the output write happen on the same edge.
  always_comb begin
    prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    long_op   = (op_q == OP_UMULL) || (op_q == OP_SMULL);
    last_iter = (cnt_q == CW'(WIDTH - 1));
    unique case (op_q)
      OP_SMULL: final_p = neg_q ? -prod_step : prod_step;
      OP_MLA:   final_p = prod_step + {{WIDTH{1'b0}}, acc_q};
      default:  final_p = prod_step;
    endcase
  end

  // This block computes the next state for the controller and the datapath.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    extra_d  = extra_q;
    flags_d  = flags_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_CALC;
          op_d     = mulop_t'(MulOp);
          acc_d    = Acc;
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = (mulop_t'(MulOp) == OP_SMULL) && (A[WIDTH-1] ^ B[WIDTH-1]);
          prod_d   = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
        end else begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
        end
      end
      S_CALC: begin
        prod_d   = prod_step;
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = final_p[WIDTH-1:0];
          extra_d  = final_p[W2-1:WIDTH];
          flags_d  = {long_op ? final_p[W2-1] : final_p[WIDTH-1],
                      long_op ? (final_p == '0) : (final_p[WIDTH-1:0] == '0),
                      2'b00};
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // This block registers all state and outputs. A reset clears everything and discards any operation in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      extra_q  <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      extra_q  <= extra_d;
      flags_q  <= flags_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign Result      = result_q;
  assign ResultExtra = extra_q;
  assign Flags       = flags_q;

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: scoreboard bench for mul_unit at WIDTH=32 and WIDTH=8.
module tb_mul_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start32, start8;
  logic [1:0]  op32, op8;
  logic [31:0] a32, b32, acc32;
  logic [7:0]  a8, b8, acc8;
  logic        busy32, done32, busy8, done8;
  logic [31:0] r32, x32;
  logic [7:0]  r8, x8;
  logic [3:0]  f32, f8;

  mul_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .MulOp(op32),
    .A(a32), .B(b32), .Acc(acc32),
    .busy(busy32), .done(done32),
    .Result(r32), .ResultExtra(x32), .Flags(f32)
  );

  mul_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .MulOp(op8),
    .A(a8), .B(b8), .Acc(acc8),
    .busy(busy8), .done(done8),
    .Result(r8), .ResultExtra(x8), .Flags(f8)
  );

  typedef struct {
    logic [31:0] r;
    logic [31:0] x;
    logic [3:0]  f;
    longint      cyc;
  } exp_t;

  exp_t   q32[$];
  exp_t   q8[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     pushes32 = 0, pushes8 = 0, dones32 = 0, dones8 = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // This is the reference model. It takes plain integer products on signed or unsigned values and reduces them modulo 2^(2w).
  function automatic exp_t model(input int w, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] acc, input longint c);
    logic [63:0] p, m, lm, ua, ub;
    longint      sa, sb;
    exp_t        e;
    m  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    lm = (64'd1 << w) - 64'd1;
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b11: begin
        sa = a[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb = b[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        p  = sa * sb;
        p  = p & m;
      end
      2'b01:   p = (ua * ub + {32'd0, acc}) & m;
      default: p = (ua * ub) & m;
    endcase
    e.r    = 32'(p & lm);
    e.x    = 32'((p >> w) & lm);
    e.f[3] = op[1] ? p[2*w-1] : p[w-1];
    e.f[2] = op[1] ? (p == 64'd0) : (e.r == 32'd0);
    e.f[1:0] = 2'b00;
    e.cyc  = c + longint'(w);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic go32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] acc, input bit push);
    int t;
    t = 0;
    @(negedge clk);
    while (busy32 && t < 200) begin @(negedge clk); t++; end
    if (busy32) chk("idle_wait32", 64'd1, 64'd0);
    op32 = op; a32 = a; b32 = b; acc32 = acc; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    if (push) begin q32.push_back(model(32, op, a, b, acc, cyc)); pushes32++; end
  endtask

  task automatic go8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] acc);
    int t;
    t = 0;
    @(negedge clk);
    while (busy8 && t < 100) begin @(negedge clk); t++; end
    if (busy8) chk("idle_wait8", 64'd1, 64'd0);
    op8 = op; a8 = a; b8 = b; acc8 = acc; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    q8.push_back(model(8, op, {24'd0, a}, {24'd0, b}, {24'd0, acc}, cyc));
    pushes8++;
  endtask

  initial begin
    exp_t e;
    int   t;
    reset = 1'b0; start32 = 1'b0; start8 = 1'b0;
    op32 = 2'b00; a32 = '0; b32 = '0; acc32 = '0;
    op8 = 2'b00; a8 = '0; b8 = '0; acc8 = '0;

    // The monitor pops the expected entry on each done and compares it, including the latency in cycles.
    fork
      forever begin
        @(negedge clk);
        chk("busy_done_excl32", 64'(busy32 & done32), 64'd0);
        chk("busy_done_excl8", 64'(busy8 & done8), 64'd0);
        if (done32) begin
          dones32++;
          if (q32.size() == 0) chk("unexpected_done32", 64'd1, 64'd0);
          else begin
            e = q32.pop_front();
            chk("result32", 64'(r32), 64'(e.r));
            chk("extra32", 64'(x32), 64'(e.x));
            chk("flags32", 64'(f32), 64'(e.f));
            chk("latency32", 64'(cyc), 64'(e.cyc));
          end
        end
        if (done8) begin
          dones8++;
          if (q8.size() == 0) chk("unexpected_done8", 64'd1, 64'd0);
          else begin
            e = q8.pop_front();
            chk("result8", 64'(r8), 64'(e.r[7:0]));
            chk("extra8", 64'(x8), 64'(e.x[7:0]));
            chk("flags8", 64'(f8), 64'(e.f));
            chk("latency8", 64'(cyc), 64'(e.cyc));
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state32", {29'd0, busy32, done32, f32, r32 | x32}, 64'd0);
    chk("reset_state8", {43'd0, busy8, done8, f8, r8, x8}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // These are the directed cases at WIDTH=32.
    go32(2'b00, 32'hFFFF_FFFE, 32'd3, 32'd0, 1'b1);
    go32(2'b11, 32'hFFFF_FFFB, 32'd10, 32'd0, 1'b1);
    go32(2'b11, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1);

    // These are the random cases at WIDTH=32.
    for (int i = 0; i < 20; i++)
      go32(2'($urandom_range(0, 3)), pick32(), pick32(), $urandom, 1'b1);

    // This case holds start high across two operations, so the second is accepted in the DONE cycle of the first.
    @(negedge clk);
    t = 0;
    while (busy32 && t < 200) begin @(negedge clk); t++; end
    op32 = 2'b10; a32 = 32'd10; b32 = 32'd45; acc32 = 32'd0; start32 = 1'b1;
    @(posedge clk); #1;
    q32.push_back(model(32, 2'b10, 32'd10, 32'd45, 32'd0, cyc)); pushes32++;
    op32 = 2'b01; a32 = 32'h0001_0000; b32 = 32'h0001_0000; acc32 = 32'd5;
    q32.push_back(model(32, 2'b01, 32'h0001_0000, 32'h0001_0000, 32'd5, cyc + 33)); pushes32++;
    repeat (33) @(posedge clk);
    #1;
    start32 = 1'b0;

    // This case pulses start with new operands while busy is high. The pulse must be ignored.
    go32(2'b00, 32'd1234, 32'd5678, 32'd0, 1'b1);
    repeat (5) @(negedge clk);
    op32 = 2'b10; a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (60) @(negedge clk);

    // These are the WIDTH=8 cases: the directed values first, then random ones.
    go8(2'b11, 8'h80, 8'hFF, 8'h00);
    go8(2'b00, 8'hFF, 8'hFF, 8'h00);
    for (int i = 0; i < 16; i++)
      go8(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom));

    t = 0;
    while ((q32.size() != 0 || q8.size() != 0) && t < 500) begin @(negedge clk); t++; end
    chk("drain", 64'(q32.size() + q8.size()), 64'd0);

    // This case asserts reset partway through CALC. The operation is dropped and no done follows.
    go32(2'b11, 32'hFFFF_0001, 32'h0000_7777, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_busy32", 64'(busy32), 64'd0);
    chk("reset_done32", 64'(done32), 64'd0);
    chk("reset_out32", {32'd0, r32 | x32}, 64'd0);
    chk("reset_flags32", 64'(f32), 64'd0);
    chk("reset_out8", {44'd0, f8, r8, x8}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (45) @(negedge clk);
    chk("done_count32", 64'(dones32), 64'(pushes32));
    chk("done_count8", 64'(dones8), 64'(pushes8));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
